// File: rtl/core_pkg.sv
// Shared core definitions: immediate type codes and base opcodes used by both
// the decode-stage immediate generator and the debug-module instruction encoder.
package core_pkg;

    // ImmSrc coding, identical to the decode-stage immediate generator.
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_LUI    = 7'h37;

    // True when v[31:lsb] are all equal, i.e. v is a sign extension of v[lsb:0].
    function automatic logic sext_fits(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] t;
        t = 32'($signed(v) >>> lsb);
        return (t == 32'h0) || (t == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// imm_pack: combinational RV32I immediate packing and representability check.
// Build option: IMM_CHECK_EN enables err; when undefined err is tied low and
// out-of-range immediates are silently truncated.
module imm_pack
    import core_pkg::*;
(
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    output logic [31:0] instr,
    output logic        err
);

    imm_src_e src;
    assign src = imm_src_e'(imm_src);

    // Scatter the immediate into the instruction format selected by src.
    always_comb begin
        instr = 32'h0;
        unique case (src)
            IMM_I:   instr = {imm[11:0], rs1, funct3, rd, opcode};
            IMM_S:   instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            IMM_B:   instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            IMM_J:   instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            IMM_U:   instr = {imm[31:12], rd, opcode};
            default: instr = 32'h0;
        endcase
    end

`ifdef IMM_CHECK_EN
    // Flag immediates that would not decode back to the same value.
    always_comb begin
        err = 1'b0;
        unique case (src)
            IMM_I, IMM_S: err = !sext_fits(imm, 11);
            IMM_B:        err = !sext_fits(imm, 12) || imm[0];
            IMM_J:        err = !sext_fits(imm, 20) || imm[0];
            IMM_U:        err = (imm[11:0] != 12'h0);
            default:      err = 1'b1;
        endcase
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline around imm_pack.
// Build option: IMM_CHECK_EN (see imm_pack) enables the err output.
module imm_encoder
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err
);

    logic [31:0] pack_instr;
    logic        pack_err;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_instr_q;
    logic        s1_err_q;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_instr_q;
    logic        s2_err_q;

    logic        accept;
    logic        s1_move;

    imm_pack u_pack (
        .imm_src (imm_src),
        .imm     (imm),
        .opcode  (opcode),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .funct3  (funct3),
        .instr   (pack_instr),
        .err     (pack_err)
    );

    // A free slot anywhere, or a draining s2, lets a new request in.
    assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign s1_move  = s1_valid_q && (!s2_valid_q || out_ready);

    // Next-state valids; flush overrides both handshakes.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (s1_move) begin
                s1_valid_d = 1'b0;
            end
            if (s1_move) begin
                s2_valid_d = 1'b1;
            end else if (out_ready) begin
                s2_valid_d = 1'b0;
            end
        end
    end

    // Pipeline registers; s2 data only changes when s1 moves, so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= 32'h0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= 32'h0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (accept) begin
                s1_instr_q <= pack_instr;
                s1_err_q   <= pack_err;
            end
            if (s1_move && !flush) begin
                s2_instr_q <= s1_instr_q;
                s2_err_q   <= s1_err_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign instr     = s2_instr_q;
    assign err       = s2_err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors, latency, backpressure,
// flush, asynchronous reset and a random round trip through an immediate decoder.
module tb_imm_encoder;

`ifdef IMM_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  imm_src = 3'b0;
    logic [31:0] imm = 32'h0;
    logic [6:0]  opcode = 7'h0;
    logic [4:0]  rd = 5'h0;
    logic [4:0]  rs1 = 5'h0;
    logic [4:0]  rs2 = 5'h0;
    logic [2:0]  funct3 = 3'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] instr;
    logic        err;

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_src   (imm_src),
        .imm       (imm),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        rt;
        logic [2:0]  src;
        logic [31:0] imm;
    } sb_t;

    vec_t vec [7];
    sb_t  sb_q [$];
    sb_t  mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Decode-stage immediate generator reference.
    function automatic logic [31:0] dec_imm(input logic [2:0] s, input logic [31:0] i);
        case (s)
            3'b000:  return {{20{i[31]}}, i[31:20]};
            3'b001:  return {{20{i[31]}}, i[31:25], i[11:7]};
            3'b010:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'b011:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'b100:  return {i[31:12], 12'h0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic sb_t sb_of(input vec_t v);
        sb_t e;
        e.instr = v.exp_instr;
        e.err   = v.exp_err & CHK_EN;
        e.rt    = 1'b0;
        e.src   = v.src;
        e.imm   = v.imm;
        return e;
    endfunction

    task automatic drive(input vec_t v);
        imm_src  = v.src;
        imm      = v.imm;
        opcode   = v.op;
        rd       = v.rd;
        rs1      = v.rs1;
        rs2      = v.rs2;
        funct3   = v.f3;
        in_valid = 1'b1;
    endtask

    // Wait (bounded) for acceptance of the driven request, then record its expectation.
    task automatic handshake(input sb_t e);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb_q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check_eq("drain", sb_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: compare each delivered word against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.rt) begin
                    check_eq("roundtrip_imm", dec_imm(mon_e.src, instr), mon_e.imm);
                end else begin
                    check_eq("instr", instr, mon_e.instr);
                end
                check_eq("err", {31'b0, err}, {31'b0, mon_e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t e;
        int  idx;
        int  tmp;
        logic rdy;
        logic [31:0] held;
        vec_t rv;

        vec[0] = '{3'b000, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF0_0093, 1'b0};
        vec[1] = '{3'b010, 32'h0000_0800, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_00E3, 1'b0};
        vec[2] = '{3'b100, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_52B7, 1'b0};
        vec[3] = '{3'b000, 32'h0000_0800, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'h8000_0013, 1'b1};
        vec[4] = '{3'b011, 32'h0000_0001, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_006F, 1'b1};
        vec[5] = '{3'b111, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0000, 1'b1};
        vec[6] = '{3'b001, 32'hFFFF_FFFC, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 32'hFE21_AE23, 1'b0};

        // Reset state
        #12;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_err", {31'b0, err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Latency: accepted at one edge, visible after the following edge
        drive(vec[0]);
        handshake(sb_of(vec[0]));
        @(negedge clk);
        check_eq("lat_n1", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check_eq("lat_n2", {31'b0, out_valid}, 32'd1);
        wait_drain();

        // Directed vectors back to back
        for (int k = 1; k < 7; k++) begin
            drive(vec[k]);
            handshake(sb_of(vec[k]));
        end
        wait_drain();

        // Backpressure: only two words fit while out_ready is low
        out_ready = 1'b0;
        idx = 0;
        drive(vec[0]);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy && idx < 4) begin
                sb_q.push_back(sb_of(vec[idx]));
                idx++;
                #1 drive(vec[idx]);
            end
        end
        #1;
        check_eq("bp_accepts", idx, 32'd2);
        check_eq("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("bp_out_valid", {31'b0, out_valid}, 32'd1);
        held = instr;
        check_eq("bp_head", instr, vec[0].exp_instr);
        @(posedge clk);
        #1;
        check_eq("bp_stable", instr, held);
        out_ready = 1'b1;
        #1;
        check_eq("bp_ready_comb", {31'b0, in_ready}, 32'd1);
        handshake(sb_of(vec[2]));
        drive(vec[3]);
        handshake(sb_of(vec[3]));
        wait_drain();

        // Flush drops in-flight and same-cycle requests
        drive(vec[2]);
        @(negedge clk);
        check_eq("fl_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 drive(vec[1]);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("fl_out_valid", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        drive(vec[6]);
        handshake(sb_of(vec[6]));
        drive(vec[2]);
        handshake(sb_of(vec[2]));
        @(negedge clk);
        check_eq("ar_pre_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("ar_instr", instr, 32'h0);
        check_eq("ar_err", {31'b0, err}, 32'd0);
        sb_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("ar_quiet", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Random legal round trip through the decoder reference
        for (int k = 0; k < 24; k++) begin
            rv.src = 3'($urandom_range(0, 4));
            case (rv.src)
                3'b000, 3'b001: tmp = int'($urandom_range(0, 4095)) - 2048;
                3'b010:         tmp = (int'($urandom_range(0, 4095)) - 2048) * 2;
                3'b011:         tmp = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
                default:        tmp = int'($urandom & 32'hFFFF_F000);
            endcase
            rv.imm = tmp;
            rv.op  = 7'($urandom);
            rv.rd  = 5'($urandom);
            rv.rs1 = 5'($urandom);
            rv.rs2 = 5'($urandom);
            rv.f3  = 3'($urandom);
            rv.exp_instr = 32'h0;
            rv.exp_err   = 1'b0;
            e = sb_of(rv);
            e.rt = 1'b1;
            drive(rv);
            handshake(e);
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
